// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage core's pipeline control.
// Contents:
//   result_src_e : execute-stage result select (ALU, memory load, PC+4)
//   fwd_sel_e    : execute-stage operand forward select
//   hz_state_e   : hazard controller memory-wait state machine
package pipe_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// Pipeline -> controller:
//   Rs1D, Rs2D                    decode-stage sources
//   Rs1E, Rs2E, RdE, ResultSrcE,
//   RegWriteE, PCSrcE             execute-stage fields
//   RdM, RegWriteM, MemReqM,
//   MemReadyM                     memory-stage destination and data handshake
//   RdW, RegWriteW                writeback-stage destination
// Controller -> pipeline:
//   StallF/D/E/M, FlushD/E        pipeline register hold / bubble controls
//   ForwardAE, ForwardBE          execute operand forward selects
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] Rs1D;
    logic [ADDR_W-1:0] Rs2D;
    logic [ADDR_W-1:0] Rs1E;
    logic [ADDR_W-1:0] Rs2E;
    logic [ADDR_W-1:0] RdE;
    logic [1:0]        ResultSrcE;
    logic              RegWriteE;
    logic              PCSrcE;
    logic [ADDR_W-1:0] RdM;
    logic              RegWriteM;
    logic              MemReqM;
    logic              MemReadyM;
    logic [ADDR_W-1:0] RdW;
    logic              RegWriteW;

    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushD;
    logic              FlushE;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, RegWriteE, PCSrcE,
               RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, RegWriteE, PCSrcE,
               RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
        output StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward select for one execute-stage operand (purely combinational).
// Ports:
//   RsE_i        execute-stage source register of this operand
//   RdM_i        memory-stage destination, RegWriteM_i its write enable
//   RdW_i        writeback-stage destination, RegWriteW_i its write enable
//   Fwd_o        FWD_MEM / FWD_WB / FWD_RF
module hazard_fwd_sel
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] RsE_i,
    input  logic [ADDR_W-1:0] RdM_i,
    input  logic              RegWriteM_i,
    input  logic [ADDR_W-1:0] RdW_i,
    input  logic              RegWriteW_i,
    output logic [1:0]        Fwd_o
);

    // The memory stage holds the younger result, so it wins over writeback.
    // x0 is hardwired to zero and is never a forwarding source.
    always_comb begin
        Fwd_o = FWD_RF;
        if (RegWriteM_i && (RdM_i != '0) && (RdM_i == RsE_i)) begin
            Fwd_o = FWD_MEM;
        end else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == RsE_i)) begin
            Fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Ports:
//   clk, rst_n   core clock (rising edge), asynchronous active-low reset
//   hz           pipeline bundle (slave side): hazard inputs in, stall/flush/
//                forward controls out
//   mem_err      sticky flag, set when a data access waits too long
//   stall_cnt    saturating count of cycles with StallF high
//   flush_cnt    saturating count of cycles with FlushE high (outside reset)
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] waitNext;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;

    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic       lwStall;
    logic       memStall;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;

    hazard_fwd_sel #(.ADDR_W(ADDR_W)) uFwdA (
        .RsE_i       (hz.Rs1E),
        .RdM_i       (hz.RdM),
        .RegWriteM_i (hz.RegWriteM),
        .RdW_i       (hz.RdW),
        .RegWriteW_i (hz.RegWriteW),
        .Fwd_o       (fwdA)
    );

    hazard_fwd_sel #(.ADDR_W(ADDR_W)) uFwdB (
        .RsE_i       (hz.Rs2E),
        .RdM_i       (hz.RdM),
        .RegWriteM_i (hz.RegWriteM),
        .RdW_i       (hz.RdW),
        .RegWriteW_i (hz.RegWriteW),
        .Fwd_o       (fwdB)
    );

    // A load in execute whose destination is read by the instruction in
    // decode cannot be forwarded in time, so decode must wait one cycle.
    assign lwStall = (hz.ResultSrcE == RES_MEM) && hz.RegWriteE &&
                     (hz.RdE != '0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    assign memStall = hz.MemReqM && !hz.MemReadyM;

    assign waitNext = wait_cnt_q + WAIT_W'(1);

    // Run-mode control priority. A memory stall freezes the whole pipe, so a
    // taken branch sitting in execute is held and only acted on once memory
    // releases. A taken branch squashes the dependent instruction, which
    // makes a simultaneous load-use stall pointless.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (hz.PCSrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lwStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // While reset is held the pipeline registers are bubbled and nothing is
    // stalled or forwarded, independent of whatever the datapath presents.
    assign hz.StallF    = rst_n & stallF;
    assign hz.StallD    = rst_n & stallD;
    assign hz.StallE    = rst_n & stallE;
    assign hz.StallM    = rst_n & stallM;
    assign hz.FlushD    = !rst_n | flushD;
    assign hz.FlushE    = !rst_n | flushE;
    assign hz.ForwardAE = rst_n ? fwdA : FWD_RF;
    assign hz.ForwardBE = rst_n ? fwdB : FWD_RF;

    // Memory-wait FSM. The stall itself is combinational from memStall; this
    // machine only tracks how long the current access has been outstanding.
    // wait_cnt stops at its limit so it cannot wrap back under the threshold,
    // and mem_err is sticky until reset. The stall is never broken off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    wait_cnt_q <= '0;
                    if (memStall) begin
                        state_q <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (hz.MemReadyM) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else begin
                        if (wait_cnt_q < WAIT_MAX) begin
                            wait_cnt_q <= waitNext;
                        end
                        if (waitNext >= WAIT_MAX) begin
                            mem_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign mem_err = mem_err_q;

    // Performance counters stick at all-ones rather than wrapping, so a
    // saturated value always means "at least this many".
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flushE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// A main instance (CNT_W = 32) and a second instance with 4-bit counters see
// identical stimulus so counter saturation is exercised alongside everything
// else. Expected control outputs are queued when stimulus is driven and
// popped when the outputs are sampled mid-cycle.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int ADDR_W      = 6;
    localparam int CNT_W       = 32;
    localparam int SAT_W       = 4;
    localparam int MEM_TIMEOUT = 64;
    localparam int SAT_MAX     = (1 << SAT_W) - 1;

    typedef struct packed {
        logic [5:0] rs1D;
        logic [5:0] rs2D;
        logic [5:0] rs1E;
        logic [5:0] rs2E;
        logic [5:0] rdE;
        logic [1:0] resultSrcE;
        logic       regWriteE;
        logic       pcSrcE;
        logic [5:0] rdM;
        logic       regWriteM;
        logic       memReqM;
        logic       memReadyM;
        logic [5:0] rdW;
        logic       regWriteW;
    } stim_t;

    typedef struct packed {
        logic       stallF;
        logic       stallD;
        logic       stallE;
        logic       stallM;
        logic       flushD;
        logic       flushE;
        logic [1:0] fwdA;
        logic [1:0] fwdB;
    } resp_t;

    typedef struct {
        stim_t stim;
        resp_t exp;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             memErr;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic             satMemErr;
    logic [SAT_W-1:0] satStallCnt;
    logic [SAT_W-1:0] satFlushCnt;

    int    checks;
    int    errors;
    int    expStall;
    int    expFlush;
    logic  expMemErr;
    resp_t expQ[$];
    vec_t  vecs[$];

    hazard_ctrl_if #(.ADDR_W(ADDR_W)) busIf ();
    hazard_ctrl_if #(.ADDR_W(ADDR_W)) satIf ();

    assign satIf.Rs1D       = busIf.Rs1D;
    assign satIf.Rs2D       = busIf.Rs2D;
    assign satIf.Rs1E       = busIf.Rs1E;
    assign satIf.Rs2E       = busIf.Rs2E;
    assign satIf.RdE        = busIf.RdE;
    assign satIf.ResultSrcE = busIf.ResultSrcE;
    assign satIf.RegWriteE  = busIf.RegWriteE;
    assign satIf.PCSrcE     = busIf.PCSrcE;
    assign satIf.RdM        = busIf.RdM;
    assign satIf.RegWriteM  = busIf.RegWriteM;
    assign satIf.MemReqM    = busIf.MemReqM;
    assign satIf.MemReadyM  = busIf.MemReadyM;
    assign satIf.RdW        = busIf.RdW;
    assign satIf.RegWriteW  = busIf.RegWriteW;

    hazard_ctrl #(
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (busIf),
        .mem_err   (memErr),
        .stall_cnt (stallCnt),
        .flush_cnt (flushCnt)
    );

    hazard_ctrl #(
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (SAT_W)
    ) dutSat (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (satIf),
        .mem_err   (satMemErr),
        .stall_cnt (satStallCnt),
        .flush_cnt (satFlushCnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic resp_t resp(input logic sf, input logic sd, input logic se,
                                   input logic sm, input logic fd, input logic fe,
                                   input logic [1:0] fa, input logic [1:0] fb);
        resp_t r;
        r = '{stallF: sf, stallD: sd, stallE: se, stallM: sm,
              flushD: fd, flushE: fe, fwdA: fa, fwdB: fb};
        return r;
    endfunction

    function automatic stim_t fwdStim(input logic [5:0] rs1E, input logic [5:0] rs2E,
                                      input logic [5:0] rdM, input logic rwM,
                                      input logic [5:0] rdW, input logic rwW);
        stim_t s;
        s           = '0;
        s.rs1E      = rs1E;
        s.rs2E      = rs2E;
        s.rdM       = rdM;
        s.regWriteM = rwM;
        s.rdW       = rdW;
        s.regWriteW = rwW;
        return s;
    endfunction

    function automatic stim_t ldStim(input logic [5:0] rs1D, input logic [5:0] rs2D,
                                     input logic [5:0] rdE, input logic [1:0] resSrc,
                                     input logic rwE, input logic pc);
        stim_t s;
        s            = '0;
        s.rs1D       = rs1D;
        s.rs2D       = rs2D;
        s.rdE        = rdE;
        s.resultSrcE = resSrc;
        s.regWriteE  = rwE;
        s.pcSrcE     = pc;
        return s;
    endfunction

    function automatic stim_t memStim(input logic req, input logic rdy, input logic pc);
        stim_t s;
        s           = '0;
        s.memReqM   = req;
        s.memReadyM = rdy;
        s.pcSrcE    = pc;
        return s;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveStim(input stim_t s);
        busIf.Rs1D       = s.rs1D;
        busIf.Rs2D       = s.rs2D;
        busIf.Rs1E       = s.rs1E;
        busIf.Rs2E       = s.rs2E;
        busIf.RdE        = s.rdE;
        busIf.ResultSrcE = s.resultSrcE;
        busIf.RegWriteE  = s.regWriteE;
        busIf.PCSrcE     = s.pcSrcE;
        busIf.RdM        = s.rdM;
        busIf.RegWriteM  = s.regWriteM;
        busIf.MemReqM    = s.memReqM;
        busIf.MemReadyM  = s.memReadyM;
        busIf.RdW        = s.rdW;
        busIf.RegWriteW  = s.regWriteW;
    endtask

    task automatic applyStimulus(input stim_t s, input resp_t e);
        driveStim(s);
        expQ.push_back(e);
    endtask

    function automatic resp_t sampleResp();
        resp_t r;
        r = '{stallF: busIf.StallF, stallD: busIf.StallD, stallE: busIf.StallE,
              stallM: busIf.StallM, flushD: busIf.FlushD, flushE: busIf.FlushE,
              fwdA: busIf.ForwardAE, fwdB: busIf.ForwardBE};
        return r;
    endfunction

    // Compare controls mid-cycle, then after the next edge compare the
    // counters and error flag against the bench's running model.
    task automatic checkOutput(input string tag);
        resp_t e;
        resp_t act;
        @(negedge clk);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e   = expQ.pop_front();
            act = sampleResp();
            checkVal({tag, " ctrl"}, 32'(act), 32'(e));
            if (e.stallF) expStall++;
            if (e.flushE) expFlush++;
        end
        @(posedge clk);
        #1;
        checkVal({tag, " stall_cnt"}, stallCnt, 32'(expStall));
        checkVal({tag, " flush_cnt"}, flushCnt, 32'(expFlush));
        checkVal({tag, " sat stall_cnt"}, 32'(satStallCnt),
                 32'((expStall > SAT_MAX) ? SAT_MAX : expStall));
        checkVal({tag, " sat flush_cnt"}, 32'(satFlushCnt),
                 32'((expFlush > SAT_MAX) ? SAT_MAX : expFlush));
        checkVal({tag, " mem_err"}, 32'(memErr), 32'(expMemErr));
    endtask

    // Main sequence: reset, table vectors, then memory-wait, timeout and
    // reset-during-wait scenarios.
    initial begin
        stim_t s;
        vec_t  v;

        checks    = 0;
        errors    = 0;
        expStall  = 0;
        expFlush  = 0;
        expMemErr = 1'b0;

        v.stim = '0;                                   v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(0, 3, 3, RES_MEM, 1, 0);       v.exp = resp(1,1,0,0,0,1,2'b00,2'b00); vecs.push_back(v);
        v.stim = '0;                                   v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = fwdStim(5, 0, 5, 1, 5, 1);            v.exp = resp(0,0,0,0,0,0,2'b10,2'b00); vecs.push_back(v);
        v.stim = fwdStim(5, 0, 5, 0, 5, 1);            v.exp = resp(0,0,0,0,0,0,2'b01,2'b00); vecs.push_back(v);
        v.stim = fwdStim(0, 0, 0, 1, 0, 1);            v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = fwdStim(9, 7, 9, 1, 7, 1);            v.exp = resp(0,0,0,0,0,0,2'b10,2'b01); vecs.push_back(v);
        v.stim = fwdStim(0, 4, 4, 1, 4, 1);            v.exp = resp(0,0,0,0,0,0,2'b00,2'b10); vecs.push_back(v);
        v.stim = fwdStim(5, 5, 5, 0, 5, 0);            v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(3, 0, 3, RES_MEM, 1, 0);       v.exp = resp(1,1,0,0,0,1,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(0, 3, 3, RES_ALU, 1, 0);       v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(0, 3, 3, RES_PC4, 1, 0);       v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(0, 0, 0, RES_MEM, 1, 0);       v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(0, 3, 3, RES_MEM, 0, 0);       v.exp = resp(0,0,0,0,0,0,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(0, 3, 3, RES_MEM, 1, 1);       v.exp = resp(0,0,0,0,1,1,2'b00,2'b00); vecs.push_back(v);
        v.stim = ldStim(0, 0, 0, RES_ALU, 0, 1);       v.exp = resp(0,0,0,0,1,1,2'b00,2'b00); vecs.push_back(v);

        // Reset with forwarding and load-use conditions present.
        rst_n = 1'b0;
        s = ldStim(0, 3, 3, RES_MEM, 1, 0);
        s.rs1E = 5; s.rdM = 5; s.regWriteM = 1'b1;
        driveStim(s);
        #12;
        checkVal("reset ctrl", 32'(sampleResp()), 32'(resp(0,0,0,0,1,1,2'b00,2'b00)));
        checkVal("reset stall_cnt", stallCnt, 32'd0);
        checkVal("reset flush_cnt", flushCnt, 32'd0);
        checkVal("reset mem_err", 32'(memErr), 32'd0);
        driveStim('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stim, vecs[i].exp);
            checkOutput($sformatf("vec%0d", i));
        end

        // Three-cycle memory wait with a branch pending; the branch acts on release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(memStim(1, 0, 1), resp(1,1,1,1,0,0,2'b00,2'b00));
            checkOutput($sformatf("memwait%0d", i));
            if (i == 0) checkVal("state in wait", 32'(dut.state_q), 32'(MEM_WAIT));
        end
        applyStimulus(memStim(1, 1, 1), resp(0,0,0,0,1,1,2'b00,2'b00));
        checkOutput("memready");
        checkVal("state after ready", 32'(dut.state_q), 32'(RUN));

        // Timeout: mem_err must be clear after 63 waiting cycles and set after 64.
        for (int i = 1; i <= MEM_TIMEOUT; i++) begin
            expMemErr = (i >= MEM_TIMEOUT);
            applyStimulus(memStim(1, 0, 0), resp(1,1,1,1,0,0,2'b00,2'b00));
            checkOutput($sformatf("timeout%0d", i));
        end
        applyStimulus(memStim(1, 1, 0), resp(0,0,0,0,0,0,2'b00,2'b00));
        checkOutput("timeout ready");
        checkVal("state after timeout", 32'(dut.state_q), 32'(RUN));

        // Asynchronous reset in the middle of a wait.
        applyStimulus(memStim(1, 0, 0), resp(1,1,1,1,0,0,2'b00,2'b00));
        checkOutput("prewait");
        s = memStim(1, 0, 0);
        s.rs1E = 5; s.rdM = 5; s.regWriteM = 1'b1;
        driveStim(s);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("midreset ctrl", 32'(sampleResp()), 32'(resp(0,0,0,0,1,1,2'b00,2'b00)));
        checkVal("midreset state", 32'(dut.state_q), 32'(RUN));
        checkVal("midreset mem_err", 32'(memErr), 32'd0);
        checkVal("midreset stall_cnt", stallCnt, 32'd0);
        checkVal("midreset sat stall_cnt", 32'(satStallCnt), 32'd0);
        driveStim('0);
        expStall  = 0;
        expFlush  = 0;
        expMemErr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(ldStim(0, 3, 3, RES_MEM, 1, 0), resp(1,1,0,0,0,1,2'b00,2'b00));
        checkOutput("post reset lw");
        applyStimulus(fwdStim(0, 6, 0, 0, 6, 1), resp(0,0,0,0,0,0,2'b00,2'b01));
        checkOutput("post reset fwd");

        checkVal("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
